multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter INSTRET_WIDTH, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port opcode_i, input, 6 bits: opcode field of the instruction register.
REQ-005 The block SHALL have port funct_i, input, 6 bits: funct field of the instruction register.
REQ-006 The block SHALL have port alu_zero_i, input, 1 bit: ALU result-is-zero flag.
REQ-007 The block SHALL have port mem_ready_i, input, 1 bit: memory completes the current request this cycle.
REQ-008 The block SHALL have port alu_op_o, output, 4 bits: ALU operation, using the `ALU_OP_* encodings.
REQ-009 The block SHALL have port alu_sel_o, output, 1 bit: ALU B operand select, `ALU_SEL_REG or `ALU_SEL_IMM.
REQ-010 The block SHALL have port mem_req_o, output, 1 bit: memory request.
REQ-011 The block SHALL have port mem_we_o, output, 1 bit: memory write enable, qualified by mem_req_o.
REQ-012 The block SHALL have port mem_addr_sel_o, output, 1 bit: memory address select, 0 = PC, 1 = ALU result.
REQ-013 The block SHALL have port ir_load_o, output, 1 bit: instruction register load strobe.
REQ-014 The block SHALL have port pc_inc_o, output, 1 bit: PC += 4 strobe.
REQ-015 The block SHALL have port pc_load_o, output, 1 bit: PC load-branch-target strobe.
REQ-016 The block SHALL have port rd_sel_o, output, 1 bit: destination register select, `RD_SEL_RD or `RD_SEL_RT.
REQ-017 The block SHALL have port rd_data_sel_o, output, 1 bit: writeback source, `RD_DATA_SEL_ALU or `RD_DATA_SEL_MEM.
REQ-018 The block SHALL have port rd_en_o, output, 1 bit: register file write strobe.
REQ-019 The block SHALL have port state_o, output, 3 bits: current FSM state.
REQ-020 The block SHALL have port instret_o, output, INSTRET_WIDTH bits: retired-instruction count.

Function
REQ-021 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-022 Outputs not named active in a state SHALL be 0.
REQ-023 Except in EXEC, MEM and WB, alu_op_o SHALL be `ALU_OP_AND and alu_sel_o SHALL be 0.
REQ-024 In FETCH the block SHALL assert mem_req_o=1, mem_addr_sel_o=0 and mem_we_o=0.
REQ-025 In FETCH, when mem_ready_i=1 the block SHALL pulse ir_load_o=1 and pc_inc_o=1 and go to DECODE; otherwise it SHALL hold FETCH with mem_req_o still asserted.
REQ-026 In DECODE, with opcode RTYPE(000000), ADDI(001000), LW(100011), SW(101011) or BEQ(000100), the block SHALL go to EXEC.
REQ-027 In DECODE, with any other opcode, the block SHALL treat the instruction as a nop: it SHALL retire it and go to FETCH.
REQ-028 In EXEC, MEM and WB, alu_op_o and alu_sel_o SHALL be driven from opcode_i and funct_i and held stable for all three states.
REQ-029 For RTYPE, funct ADD(100000), SUB(100010), AND(100100), OR(100101) and SLT(101010) SHALL map to the matching `ALU_OP_* code, and any other funct SHALL map to `ALU_OP_AND; alu_sel_o SHALL be REG.
REQ-030 ADDI, LW and SW SHALL use ADD with alu_sel_o=IMM.
REQ-031 BEQ SHALL use SUB with alu_sel_o=REG.
REQ-032 On leaving EXEC: RTYPE and ADDI SHALL go to WB; LW and SW SHALL go to MEM.
REQ-033 On leaving EXEC, BEQ SHALL set pc_load_o=alu_zero_i (combinational, that cycle only), retire, and go to FETCH.
REQ-034 In MEM the block SHALL assert mem_req_o=1 and mem_addr_sel_o=1, with mem_we_o=1 for SW and 0 for LW.
REQ-035 In MEM the block SHALL hold state until mem_ready_i=1; then LW SHALL go to WB, and SW SHALL retire and go to FETCH.
REQ-036 In WB the block SHALL pulse rd_en_o=1 for one cycle, then retire and go to FETCH.
REQ-037 In WB, rd_sel_o SHALL be RD for RTYPE and RT otherwise, and rd_data_sel_o SHALL be MEM for LW and ALU otherwise.
REQ-038 With zero wait states, latency from FETCH entry to the next FETCH SHALL be: invalid 2, BEQ 3, SW 4, RTYPE/ADDI 4, LW 5 cycles; each wait cycle SHALL add exactly one.
REQ-039 instret_o SHALL increment by 1 on the edge leaving each retiring state, and SHALL wrap from all-ones to 0.
REQ-040 mem_req_o SHALL never deassert while a request is pending and mem_ready_i=0.

Reset
REQ-041 While rst_n_i=0, independent of clk_i, the block SHALL force state FETCH and instret_o=0.
REQ-042 While rst_n_i=0, all strobes (ir_load_o, pc_inc_o, pc_load_o, rd_en_o, mem_we_o) SHALL be 0; mem_req_o SHALL read 0 during reset.
REQ-043 The first FETCH request SHALL issue on the first rising edge after rst_n_i rises.
REQ-044 Reset asserted mid-instruction SHALL abort that instruction, with no strobe emitted and no retirement counted.

Verification
REQ-045 The bench SHALL drive ADD (opcode 000000, funct 100000) with mem_ready_i=1 -> states 0,1,2,4,0; rd_en_o=1 only in WB with rd_sel_o=RD; instret_o 0->1.
REQ-046 The bench SHALL drive LW with mem_ready_i=0 for 3 cycles in MEM -> MEM held 4 cycles with mem_req_o=1, mem_we_o=0, mem_addr_sel_o=1; WB has rd_data_sel_o=MEM; total 8 cycles.
REQ-047 The bench SHALL drive BEQ with alu_zero_i=1, then with alu_zero_i=0 -> pc_load_o=1 for one EXEC cycle in the first case only; 3 cycles each.
REQ-048 The bench SHALL drive SW -> MEM has mem_we_o=1; rd_en_o=0 throughout; back to FETCH after MEM.
REQ-049 The bench SHALL drive opcode 111111 -> DECODE to FETCH; no rd_en_o, mem_we_o or pc_load_o; instret_o increments.
REQ-050 The bench SHALL assert rst_n_i=0 asynchronously during MEM of SW -> state_o=0 immediately, mem_we_o=0, instret_o=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes and counts retired instructions.
`ifndef ALU_OP_AND
`define ALU_OP_AND 4'd0
`define ALU_OP_OR  4'd1
`define ALU_OP_ADD 4'd2
`define ALU_OP_SUB 4'd6
`define ALU_OP_SLT 4'd7
`endif
`ifndef ALU_SEL_REG
`define ALU_SEL_REG 1'b0
`define ALU_SEL_IMM 1'b1
`endif
`ifndef RD_SEL_RT
`define RD_SEL_RT 1'b0
`define RD_SEL_RD 1'b1
`endif
`ifndef RD_DATA_SEL_ALU
`define RD_DATA_SEL_ALU 1'b0
`define RD_DATA_SEL_MEM 1'b1
`endif

module multicycle_control #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [5:0]               opcode_i,
    input  logic [5:0]               funct_i,
    input  logic                     alu_zero_i,
    input  logic                     mem_ready_i,
    output logic [3:0]               alu_op_o,
    output logic                     alu_sel_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic                     mem_addr_sel_o,
    output logic                     ir_load_o,
    output logic                     pc_inc_o,
    output logic                     pc_load_o,
    output logic                     rd_sel_o,
    output logic                     rd_data_sel_o,
    output logic                     rd_en_o,
    output logic [2:0]               state_o,
    output logic [INSTRET_WIDTH-1:0] instret_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t                   state_q, state_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    logic                     retire;
    logic                     op_valid;
    logic [3:0]               dec_alu_op;
    logic                     dec_alu_sel;
    logic [3:0]               alu_op;
    logic                     alu_sel;
    logic                     mem_req, mem_we, mem_addr_sel;
    logic                     ir_load, pc_inc, pc_load;
    logic                     rd_sel, rd_data_sel, rd_en;

    // The IR is stable from DECODE to retirement, so decoding it combinationally
    // keeps the ALU controls constant across EXEC, MEM and WB.
    always_comb begin
        dec_alu_op  = `ALU_OP_AND;
        dec_alu_sel = `ALU_SEL_REG;
        op_valid    = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  dec_alu_op = `ALU_OP_ADD;
                    FN_SUB:  dec_alu_op = `ALU_OP_SUB;
                    FN_AND:  dec_alu_op = `ALU_OP_AND;
                    FN_OR:   dec_alu_op = `ALU_OP_OR;
                    FN_SLT:  dec_alu_op = `ALU_OP_SLT;
                    default: dec_alu_op = `ALU_OP_AND;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec_alu_op  = `ALU_OP_ADD;
                dec_alu_sel = `ALU_SEL_IMM;
            end
            OP_BEQ:  dec_alu_op = `ALU_OP_SUB;
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        alu_op       = `ALU_OP_AND;
        alu_sel      = `ALU_SEL_REG;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        rd_sel       = `RD_SEL_RT;
        rd_data_sel  = `RD_DATA_SEL_ALU;
        rd_en        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready_i) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (op_valid) begin
                    state_d = EXEC;
                end else begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                alu_op  = dec_alu_op;
                alu_sel = dec_alu_sel;
                case (opcode_i)
                    OP_LW, OP_SW:      state_d = MEM;
                    OP_RTYPE, OP_ADDI: state_d = WB;
                    OP_BEQ: begin
                        pc_load = alu_zero_i;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default:           state_d = FETCH;
                endcase
            end
            MEM: begin
                alu_op       = dec_alu_op;
                alu_sel      = dec_alu_sel;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode_i == OP_SW);
                if (mem_ready_i) begin
                    if (opcode_i == OP_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                alu_op      = dec_alu_op;
                alu_sel     = dec_alu_sel;
                rd_en       = 1'b1;
                rd_sel      = (opcode_i == OP_RTYPE) ? `RD_SEL_RD : `RD_SEL_RT;
                rd_data_sel = (opcode_i == OP_LW) ? `RD_DATA_SEL_MEM : `RD_DATA_SEL_ALU;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
        instret_d = retire ? instret_q + INSTRET_WIDTH'(1) : instret_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // State is forced to FETCH during reset, so the FETCH request and strobes
    // are masked by reset itself to keep the bus quiet.
    assign alu_op_o       = alu_op;
    assign alu_sel_o      = alu_sel;
    assign mem_req_o      = rst_n_i & mem_req;
    assign mem_we_o       = rst_n_i & mem_we;
    assign mem_addr_sel_o = rst_n_i & mem_addr_sel;
    assign ir_load_o      = rst_n_i & ir_load;
    assign pc_inc_o       = rst_n_i & pc_inc;
    assign pc_load_o      = rst_n_i & pc_load;
    assign rd_sel_o       = rst_n_i & rd_sel;
    assign rd_data_sel_o  = rst_n_i & rd_data_sel;
    assign rd_en_o        = rst_n_i & rd_en;
    assign state_o        = state_q;
    assign instret_o      = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instructions push expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam logic [3:0] A_AND = 4'd0;
    localparam logic [3:0] A_ADD = 4'd2;
    localparam logic [3:0] A_SUB = 4'd6;
    localparam logic [3:0] A_SLT = 4'd7;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // Flag order: sel req we masel irl pci pcl rds rdds rden
    localparam logic [9:0] FL_NONE       = 10'b0000000000;
    localparam logic [9:0] FL_FETCH_GO   = 10'b0100110000;
    localparam logic [9:0] FL_FETCH_WAIT = 10'b0100000000;
    localparam logic [9:0] FL_IMM        = 10'b1000000000;
    localparam logic [9:0] FL_BEQ_TAKEN  = 10'b0000001000;
    localparam logic [9:0] FL_MEM_LW     = 10'b1101000000;
    localparam logic [9:0] FL_MEM_SW     = 10'b1111000000;
    localparam logic [9:0] FL_WB_RTYPE   = 10'b0000000101;
    localparam logic [9:0] FL_WB_LW      = 10'b1000000011;
    localparam logic [9:0] FL_WB_ADDI    = 10'b1000000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_ready;
    logic [3:0]  alu_op_o;
    logic        alu_sel_o, mem_req_o, mem_we_o, mem_addr_sel_o;
    logic        ir_load_o, pc_inc_o, pc_load_o, rd_sel_o, rd_data_sel_o, rd_en_o;
    logic [2:0]  state_o;
    logic [31:0] instret_o;

    multicycle_control #(.INSTRET_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .funct_i(funct),
        .alu_zero_i(alu_zero), .mem_ready_i(mem_ready),
        .alu_op_o(alu_op_o), .alu_sel_o(alu_sel_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o),
        .ir_load_o(ir_load_o), .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
        .rd_sel_o(rd_sel_o), .rd_data_sel_o(rd_data_sel_o), .rd_en_o(rd_en_o),
        .state_o(state_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [16:0] outs;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_ret  = 0;
    logic [16:0] act;

    assign act = {state_o, alu_op_o, alu_sel_o, mem_req_o, mem_we_o, mem_addr_sel_o,
                  ir_load_o, pc_inc_o, pc_load_o, rd_sel_o, rd_data_sel_o, rd_en_o};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (act !== mon_e.outs) begin
                n_fail++;
                $display("FAIL %s outputs: got %b expected %b", mon_e.nm, act, mon_e.outs);
            end
            n_checks++;
            if (instret_o !== mon_e.ret) begin
                n_fail++;
                $display("FAIL %s instret: got %0d expected %0d", mon_e.nm, instret_o, mon_e.ret);
            end
            $display("%-22s state=%0d outs=%b instret=%0d", mon_e.nm, state_o, act, instret_o);
        end
    end

    task automatic push(input string nm, input logic [16:0] outs);
        exp_t e;
        e.nm   = nm;
        e.outs = outs;
        e.ret  = exp_ret;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                       input logic zero, input logic rdy, input logic [2:0] st,
                       input logic [3:0] aop, input logic [9:0] flags);
        @(posedge clk);
        #1;
        opcode    = opc;
        funct     = fn;
        alu_zero  = zero;
        mem_ready = rdy;
        push(nm, {st, aop, flags});
    endtask

    task automatic fetch(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                         input logic rdy);
        cyc(nm, opc, fn, 1'b0, rdy, 3'd0, A_AND, rdy ? FL_FETCH_GO : FL_FETCH_WAIT);
    endtask

    task automatic decode(input string nm, input logic [5:0] opc, input logic [5:0] fn);
        cyc(nm, opc, fn, 1'b0, 1'b1, 3'd1, A_AND, FL_NONE);
    endtask

    initial begin
        rst_n     = 1'b1;
        opcode    = OP_R;
        funct     = 6'b100000;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;
        #1 rst_n  = 1'b0;
        push("reset", {3'd0, A_AND, FL_NONE});
        #11;
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // ADD: 0,1,2,4
        fetch ("ADD fetch",  OP_R, 6'b100000, 1'b1);
        decode("ADD decode", OP_R, 6'b100000);
        cyc   ("ADD exec",   OP_R, 6'b100000, 1'b0, 1'b1, 3'd2, A_ADD, FL_NONE);
        cyc   ("ADD wb",     OP_R, 6'b100000, 1'b0, 1'b1, 3'd4, A_ADD, FL_WB_RTYPE);
        exp_ret++;

        // LW with one fetch wait and three MEM waits
        fetch ("LW fetch wait", OP_LW, 6'b000000, 1'b0);
        fetch ("LW fetch",      OP_LW, 6'b000000, 1'b1);
        decode("LW decode",     OP_LW, 6'b000000);
        cyc   ("LW exec",       OP_LW, 6'b000000, 1'b0, 1'b0, 3'd2, A_ADD, FL_IMM);
        for (int i = 0; i < 3; i++)
            cyc("LW mem wait",  OP_LW, 6'b000000, 1'b0, 1'b0, 3'd3, A_ADD, FL_MEM_LW);
        cyc   ("LW mem done",   OP_LW, 6'b000000, 1'b0, 1'b1, 3'd3, A_ADD, FL_MEM_LW);
        cyc   ("LW wb",         OP_LW, 6'b000000, 1'b0, 1'b1, 3'd4, A_ADD, FL_WB_LW);
        exp_ret++;

        // BEQ taken then not taken
        fetch ("BEQ1 fetch",  OP_BEQ, 6'b000000, 1'b1);
        decode("BEQ1 decode", OP_BEQ, 6'b000000);
        cyc   ("BEQ1 exec",   OP_BEQ, 6'b000000, 1'b1, 1'b1, 3'd2, A_SUB, FL_BEQ_TAKEN);
        exp_ret++;
        fetch ("BEQ0 fetch",  OP_BEQ, 6'b000000, 1'b1);
        decode("BEQ0 decode", OP_BEQ, 6'b000000);
        cyc   ("BEQ0 exec",   OP_BEQ, 6'b000000, 1'b0, 1'b1, 3'd2, A_SUB, FL_NONE);
        exp_ret++;

        // SW
        fetch ("SW fetch",  OP_SW, 6'b000000, 1'b1);
        decode("SW decode", OP_SW, 6'b000000);
        cyc   ("SW exec",   OP_SW, 6'b000000, 1'b0, 1'b1, 3'd2, A_ADD, FL_IMM);
        cyc   ("SW mem",    OP_SW, 6'b000000, 1'b0, 1'b1, 3'd3, A_ADD, FL_MEM_SW);
        exp_ret++;

        // Invalid opcode retires from DECODE
        fetch ("BAD fetch",  OP_BAD, 6'b000000, 1'b1);
        decode("BAD decode", OP_BAD, 6'b000000);
        exp_ret++;

        // ADDI
        fetch ("ADDI fetch",  OP_ADDI, 6'b000000, 1'b1);
        decode("ADDI decode", OP_ADDI, 6'b000000);
        cyc   ("ADDI exec",   OP_ADDI, 6'b000000, 1'b0, 1'b1, 3'd2, A_ADD, FL_IMM);
        cyc   ("ADDI wb",     OP_ADDI, 6'b000000, 1'b0, 1'b1, 3'd4, A_ADD, FL_WB_ADDI);
        exp_ret++;

        // SLT, then an unknown funct which falls back to AND
        fetch ("SLT fetch",  OP_R, 6'b101010, 1'b1);
        decode("SLT decode", OP_R, 6'b101010);
        cyc   ("SLT exec",   OP_R, 6'b101010, 1'b0, 1'b1, 3'd2, A_SLT, FL_NONE);
        cyc   ("SLT wb",     OP_R, 6'b101010, 1'b0, 1'b1, 3'd4, A_SLT, FL_WB_RTYPE);
        exp_ret++;
        fetch ("FNX fetch",  OP_R, 6'b000111, 1'b1);
        decode("FNX decode", OP_R, 6'b000111);
        cyc   ("FNX exec",   OP_R, 6'b000111, 1'b0, 1'b1, 3'd2, A_AND, FL_NONE);
        cyc   ("FNX wb",     OP_R, 6'b000111, 1'b0, 1'b1, 3'd4, A_AND, FL_WB_RTYPE);
        exp_ret++;

        // SW aborted by asynchronous reset while waiting in MEM
        fetch ("SWR fetch",  OP_SW, 6'b000000, 1'b1);
        decode("SWR decode", OP_SW, 6'b000000);
        cyc   ("SWR exec",   OP_SW, 6'b000000, 1'b0, 1'b0, 3'd2, A_ADD, FL_IMM);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1 rst_n  = 1'b0;
        exp_ret   = 0;
        push("SWR reset in MEM", {3'd0, A_AND, FL_NONE});
        @(negedge clk);
        #1 rst_n  = 1'b1;

        // ADD after reset counts from zero again
        fetch ("ADD2 fetch",  OP_R, 6'b100000, 1'b1);
        decode("ADD2 decode", OP_R, 6'b100000);
        cyc   ("ADD2 exec",   OP_R, 6'b100000, 1'b0, 1'b1, 3'd2, A_ADD, FL_NONE);
        cyc   ("ADD2 wb",     OP_R, 6'b100000, 1'b0, 1'b1, 3'd4, A_ADD, FL_WB_RTYPE);
        exp_ret++;
        fetch ("final fetch", OP_R, 6'b100000, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
